// File: rtl/axi_master_bridge.sv
// axi_master_bridge: turns the single-request read/write interface into AXI4
// master traffic on a 32-bit bus. It tracks one read per ID (0 and 1), gathers
// each read burst into a 256-bit line, and splits 256-bit write lines into beats.
`timescale 1ns/1ps
module axi_master_bridge (
  input  logic         clk,
  input  logic         resetn,
  input  logic         fsh,
  input  logic         rd_req,
  input  logic [31:0]  rd_addr,
  input  logic [7:0]   rd_len,
  input  logic [2:0]   rd_arsize,
  input  logic [3:0]   rd_arid,
  output logic [255:0] rd_data,
  output logic [3:0]   rd_rid,
  output logic [1:0]   rd_cnt,
  output logic         rd_valid,
  input  logic         wr_req,
  input  logic [31:0]  wr_addr,
  input  logic [7:0]   wr_len,
  input  logic [255:0] wr_data,
  input  logic [3:0]   wr_wstrb,
  output logic         wr_valid,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arlock,
  output logic [3:0]   arcache,
  output logic [2:0]   arprot,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awlock,
  output logic [3:0]   awcache,
  output logic [2:0]   awprot,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;

  logic [1:0]   busy;
  logic [1:0]   kill;
  logic [3:0]   beat_cnt [2];
  logic [1:0]   rd_cool  [2];
  logic [255:0] line_buf [2];
  logic         r_sel;
  logic         r_hit;
  logic         rd_accept;
  logic [255:0] merged;

  wstate_t      wstate;
  wstate_t      wstate_next;
  logic         wr_accept;
  logic [7:0]   w_beat;
  logic [7:0]   w_len_q;
  logic [31:0]  w_addr_q;
  logic [255:0] w_line;
  logic [3:0]   w_strb_q;
  logic [1:0]   w_cool;
  logic         unused_inputs;

  assign arburst = 2'b01;
  assign arlock  = 1'b0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = 4'd1;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awlock  = 1'b0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign rready  = 1'b1;
  assign bready  = 1'b1;
  assign awaddr  = w_addr_q;
  assign awlen   = w_len_q;
  assign wstrb   = w_strb_q;
  assign rd_cnt  = {1'b0, busy[0]} + {1'b0, busy[1]};
  assign unused_inputs = ^{rresp, bid, bresp};

  // Read accept decision and the line with the current R beat merged in.
  always_comb begin
    rd_accept = rd_req && !arvalid && !busy[rd_arid[0]] && (rd_cool[rd_arid[0]] == 2'd0);
    r_sel     = rid[0];
    r_hit     = rvalid && busy[r_sel];
    merged    = line_buf[r_sel];
    if (beat_cnt[r_sel] < 4'd8) begin
      merged[{beat_cnt[r_sel][2:0], 5'b00000} +: 32] = rdata;
    end
  end

  // Read path: AR issue, per-ID beat gathering, flush kill and completion.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      arvalid  <= 1'b0;
      arid     <= 4'd0;
      araddr   <= 32'd0;
      arlen    <= 8'd0;
      arsize   <= 3'd0;
      busy     <= 2'b00;
      kill     <= 2'b00;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_rid   <= 4'd0;
      for (int i = 0; i < 2; i++) begin
        beat_cnt[i] <= 4'd0;
        rd_cool[i]  <= 2'd0;
        line_buf[i] <= '0;
      end
    end else begin
      rd_valid <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (rd_cool[i] != 2'd0) rd_cool[i] <= rd_cool[i] - 2'd1;
      end
      if (arvalid && arready) arvalid <= 1'b0;
      if (fsh) kill <= kill | busy;
      if (rd_accept) begin
        arvalid              <= 1'b1;
        arid                 <= rd_arid;
        araddr               <= rd_addr;
        arlen                <= rd_len;
        arsize               <= rd_arsize;
        busy[rd_arid[0]]     <= 1'b1;
        kill[rd_arid[0]]     <= 1'b0;
        beat_cnt[rd_arid[0]] <= 4'd0;
        line_buf[rd_arid[0]] <= '0;
      end
      if (r_hit) begin
        line_buf[r_sel] <= merged;
        if (beat_cnt[r_sel] < 4'd8) beat_cnt[r_sel] <= beat_cnt[r_sel] + 4'd1;
        if (rlast) begin
          busy[r_sel]    <= 1'b0;
          kill[r_sel]    <= 1'b0;
          rd_cool[r_sel] <= 2'd2;
          if (!kill[r_sel] && !fsh) begin
            rd_data  <= merged;
            rd_rid   <= rid;
            rd_valid <= 1'b1;
          end
        end
      end
    end
  end

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) wstate <= W_IDLE;
    else         wstate <= wstate_next;
  end

  // Write FSM next state and AW/W channel outputs.
  always_comb begin
    wstate_next = wstate;
    wr_accept   = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    wlast       = 1'b0;
    wdata       = w_line[{w_beat[2:0], 5'b00000} +: 32];
    case (wstate)
      W_IDLE: begin
        if (wr_req && (w_cool == 2'd0)) begin
          wr_accept   = 1'b1;
          wstate_next = W_ADDR;
        end
      end
      W_ADDR: begin
        awvalid = 1'b1;
        if (awready) wstate_next = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        wlast  = (w_beat == w_len_q);
        if (wready && wlast) wstate_next = W_RESP;
      end
      W_RESP: begin
        if (bvalid) wstate_next = W_IDLE;
      end
      default: wstate_next = W_IDLE;
    endcase
  end

  // Write datapath: request capture, beat counter, completion pulse and cooldown.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_addr_q <= 32'd0;
      w_len_q  <= 8'd0;
      w_line   <= '0;
      w_strb_q <= 4'd0;
      w_beat   <= 8'd0;
      w_cool   <= 2'd0;
      wr_valid <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      if (w_cool != 2'd0) w_cool <= w_cool - 2'd1;
      if (wr_accept) begin
        w_addr_q <= wr_addr;
        w_len_q  <= wr_len;
        w_line   <= wr_data;
        w_strb_q <= wr_wstrb;
        w_beat   <= 8'd0;
      end
      if (wvalid && wready && !wlast) w_beat <= w_beat + 8'd1;
      if ((wstate == W_RESP) && bvalid) begin
        wr_valid <= 1'b1;
        w_cool   <= 2'd2;
      end
    end
  end

endmodule

// File: tb/tb_axi_master_bridge.sv
// tb_axi_master_bridge: random upstream requests and a random AXI slave drive the
// bridge; expected AXI requests, write beats and completions are queued as they
// are predicted and a separate monitor pops and compares them.
`timescale 1ns/1ps
module tb_axi_master_bridge;

  logic         clk = 1'b0;
  logic         resetn, fsh;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic [7:0]   rd_len;
  logic [2:0]   rd_arsize;
  logic [3:0]   rd_arid;
  logic [255:0] rd_data;
  logic [3:0]   rd_rid;
  logic [1:0]   rd_cnt;
  logic         rd_valid;
  logic         wr_req;
  logic [31:0]  wr_addr;
  logic [7:0]   wr_len;
  logic [255:0] wr_data;
  logic [3:0]   wr_wstrb;
  logic         wr_valid;
  logic [3:0]   arid, awid, rid, bid, arcache, awcache, wstrb;
  logic [31:0]  araddr, awaddr, rdata, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize, arprot, awprot;
  logic [1:0]   arburst, awburst, rresp, bresp;
  logic         arlock, awlock, arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  axi_master_bridge dut (
    .clk(clk), .resetn(resetn), .fsh(fsh),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_arsize(rd_arsize),
    .rd_arid(rd_arid), .rd_data(rd_data), .rd_rid(rd_rid), .rd_cnt(rd_cnt),
    .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data),
    .wr_wstrb(wr_wstrb), .wr_valid(wr_valid),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
    .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size; } ar_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
  typedef struct { logic [3:0] rid; logic [255:0] data; int cyc; } rd_t;

  ar_t ar_q[$];
  aw_t aw_q[$];
  w_t  w_q[$];
  rd_t rd_q[$];
  int  wr_q[$];

  int tests = 0;
  int fails = 0;

  // Reference model state: what the upstream has asked for and what the slave owes.
  bit           inflight [2];
  bit           killed   [2];
  bit           r_active [2];
  int           free_at  [2];
  int           r_len    [2];
  int           r_cnt    [2];
  logic [255:0] line_m   [2];
  bit ar_pending, hold_active, w_busy, aw_pending, b_wait, w_hold;
  int ar_pend_id, rq_cycle, hold_id, hold_drop, free_w, wq_cycle, aw_hs_cycle;
  int b_delay, w_hold_drop;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of upstream + slave behaviour; called #1 after each rising edge.
  task automatic applyStimulus(input bit gen);
    int c, id, k, n;
    logic [255:0] d;
    c = cyc;
    if (hold_active && c == hold_drop) begin
      rd_req = 1'b0;
      hold_active = 1'b0;
    end else if (!hold_active) rd_req = 1'b0;
    if (w_hold && c == w_hold_drop) begin
      wr_req = 1'b0;
      w_hold = 1'b0;
    end else if (!w_hold) wr_req = 1'b0;

    n = int'(inflight[0]) + int'(inflight[1]);
    checkOutput("rd_cnt", rd_cnt, n);
    if (ar_pending && c == rq_cycle + 1) checkOutput("arvalid_latency", arvalid, 1'b1);
    if (aw_pending && c == wq_cycle + 1) checkOutput("awvalid_latency", awvalid, 1'b1);
    if (c == aw_hs_cycle + 1) checkOutput("wvalid_after_aw", wvalid, 1'b1);

    fsh = gen && ($urandom % 25 == 0);
    if (fsh) for (int i = 0; i < 2; i++) if (inflight[i]) killed[i] = 1'b1;

    rvalid = 1'b0;
    rlast  = 1'b0;
    if ($urandom % 2 == 0) begin
      id = $urandom % 2;
      if (!r_active[id]) id = 1 - id;
      if (r_active[id]) begin
        k      = r_cnt[id];
        rvalid = 1'b1;
        rid    = 4'(id);
        rdata  = $urandom;
        rresp  = 2'($urandom);
        rlast  = (k == r_len[id]);
        line_m[id][k*32 +: 32] = rdata;
        r_cnt[id] = k + 1;
        if (rlast) begin
          if (!killed[id]) rd_q.push_back('{rid: 4'(id), data: line_m[id], cyc: c + 1});
          r_active[id] = 1'b0;
          inflight[id] = 1'b0;
          killed[id]   = 1'b0;
          free_at[id]  = c + 3;
          if (hold_active && hold_id == id) hold_drop = c + 3;
        end
      end
    end

    bvalid = 1'b0;
    if (b_wait) begin
      if (b_delay == 0) begin
        bvalid = 1'b1;
        bid    = 4'd1;
        bresp  = 2'($urandom);
        wr_q.push_back(c + 1);
        b_wait = 1'b0;
        w_busy = 1'b0;
        free_w = c + 3;
        if (w_hold) w_hold_drop = c + 3;
      end else b_delay--;
    end

    if (gen && !ar_pending && !hold_active && !rd_req && ($urandom % 3 == 0)) begin
      id = $urandom % 2;
      if (!inflight[id] && c >= free_at[id]) begin
        rd_req    = 1'b1;
        rd_arid   = 4'(id);
        rd_addr   = $urandom;
        rd_len    = 8'($urandom % 8);
        rd_arsize = 3'($urandom);
        ar_q.push_back('{id: rd_arid, addr: rd_addr, len: rd_len, size: rd_arsize});
        ar_pending   = 1'b1;
        ar_pend_id   = id;
        rq_cycle     = c;
        inflight[id] = 1'b1;
        killed[id]   = 1'b0;
        r_len[id]    = int'(rd_len);
        r_cnt[id]    = 0;
        line_m[id]   = '0;
        hold_active  = ($urandom % 3 == 0);
        hold_id      = id;
        hold_drop    = -1;
      end
    end

    if (gen && !w_busy && !w_hold && c >= free_w && ($urandom % 4 == 0)) begin
      for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
      wr_req   = 1'b1;
      wr_addr  = $urandom;
      wr_len   = 8'($urandom % 8);
      wr_data  = d;
      wr_wstrb = 4'($urandom);
      aw_q.push_back('{addr: wr_addr, len: wr_len});
      for (int j = 0; j <= int'(wr_len); j++)
        w_q.push_back('{data: d[j*32 +: 32], strb: wr_wstrb, last: (j == int'(wr_len))});
      w_busy      = 1'b1;
      aw_pending  = 1'b1;
      wq_cycle    = c;
      w_hold      = ($urandom % 2 == 0);
      w_hold_drop = -1;
    end

    arready = arvalid ? ($urandom % 3 != 0) : 1'($urandom);
    if (arvalid && arready && ar_pending) begin
      r_active[ar_pend_id] = 1'b1;
      ar_pending = 1'b0;
    end
    awready = 1'($urandom);
    if (awvalid && awready && aw_pending) begin
      aw_pending  = 1'b0;
      aw_hs_cycle = c;
    end
    wready = 1'($urandom);
    if (wvalid && wready && wlast && w_busy && !b_wait) begin
      b_wait  = 1'b1;
      b_delay = $urandom % 3;
    end
  endtask

  // Monitor: pops the scoreboard whenever the bridge presents a handshake or pulse.
  initial begin : monitor
    ar_t ae;
    aw_t we;
    w_t  be;
    rd_t re;
    int  wc;
    forever begin
      @(negedge clk);
      if (resetn) begin
        checkOutput("ready_tie", {rready, bready}, 2'b11);
        if (arvalid && arready) begin
          if (ar_q.size() == 0) checkOutput("ar_unexpected", arvalid, 1'b0);
          else begin
            ae = ar_q.pop_front();
            checkOutput("ar_fields", {arid, araddr, arlen, arsize, arburst},
                        {ae.id, ae.addr, ae.len, ae.size, 2'b01});
          end
        end
        if (awvalid && awready) begin
          if (aw_q.size() == 0) checkOutput("aw_unexpected", awvalid, 1'b0);
          else begin
            we = aw_q.pop_front();
            checkOutput("aw_fields", {awid, awaddr, awlen, awsize, awburst},
                        {4'd1, we.addr, we.len, 3'b010, 2'b01});
          end
        end
        if (wvalid && wready) begin
          if (w_q.size() == 0) checkOutput("w_unexpected", wvalid, 1'b0);
          else begin
            be = w_q.pop_front();
            checkOutput("w_beat", {wdata, wstrb, wlast}, {be.data, be.strb, be.last});
          end
        end
        if (rd_valid) begin
          if (rd_q.size() == 0) checkOutput("rd_valid_unexpected", rd_valid, 1'b0);
          else begin
            re = rd_q.pop_front();
            checkOutput("rd_rid", rd_rid, re.rid);
            checkOutput("rd_data", rd_data, re.data);
            checkOutput("rd_valid_cycle", cyc, re.cyc);
          end
        end
        if (wr_valid) begin
          if (wr_q.size() == 0) checkOutput("wr_valid_unexpected", wr_valid, 1'b0);
          else begin
            wc = wr_q.pop_front();
            checkOutput("wr_valid_cycle", cyc, wc);
          end
        end
      end
    end
  end

  // Main sequence: reset checks, random traffic, drain, leftover checks.
  initial begin
    resetn = 1'b0; fsh = 1'b0;
    rd_req = 1'b0; rd_addr = '0; rd_len = '0; rd_arsize = '0; rd_arid = '0;
    wr_req = 1'b0; wr_addr = '0; wr_len = '0; wr_data = '0; wr_wstrb = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      inflight[i] = 0; killed[i] = 0; r_active[i] = 0; free_at[i] = 0;
      r_len[i] = 0; r_cnt[i] = 0; line_m[i] = '0;
    end
    ar_pending = 0; hold_active = 0; w_busy = 0; aw_pending = 0; b_wait = 0; w_hold = 0;
    ar_pend_id = 0; rq_cycle = -10; hold_id = 0; hold_drop = -1; free_w = 0;
    wq_cycle = -10; aw_hs_cycle = -10; b_delay = 0; w_hold_drop = -1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valids", {rd_valid, wr_valid, arvalid, awvalid, wvalid, wlast}, 6'd0);
    checkOutput("reset_rd_cnt", rd_cnt, 2'd0);
    checkOutput("reset_rd_data", rd_data, 256'd0);
    checkOutput("reset_rd_rid", rd_rid, 4'd0);
    checkOutput("reset_addr_len", {araddr, awaddr, arlen, awlen}, 80'd0);
    checkOutput("reset_ready", {rready, bready}, 2'b11);
    checkOutput("const_attrs", {arlock, arcache, arprot, awlock, awcache, awprot}, 16'd0);
    resetn = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      applyStimulus(1'b1);
    end
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      applyStimulus(1'b0);
      if (!ar_pending && !r_active[0] && !r_active[1] && !inflight[0] && !inflight[1] &&
          !w_busy && !hold_active && !w_hold) break;
    end
    repeat (5) begin
      @(posedge clk); #1;
      applyStimulus(1'b0);
    end
    checkOutput("drain_ar", ar_q.size(), 0);
    checkOutput("drain_aw", aw_q.size(), 0);
    checkOutput("drain_w", w_q.size(), 0);
    checkOutput("drain_rd_completions", rd_q.size(), 0);
    checkOutput("drain_wr_completions", wr_q.size(), 0);
    checkOutput("drain_inflight", {inflight[0], inflight[1], w_busy}, 3'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
